// File: rtl/key_event.sv
// Key event classifier: turns a debounced key level into press/release/short/long pulses.
// Optional auto-repeat while long-held is enabled by defining KEY_EVENT_REPEAT_EN.
module key_event #(
    parameter logic [31:0] LONG_CYCLES   = 32'd100000000,
    parameter logic [31:0] REPEAT_CYCLES = 32'd20000000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESSED = 2'd1;
    localparam logic [1:0] LONG    = 2'd2;

    localparam logic [31:0] LONG_M1 = LONG_CYCLES - 32'd1;

    logic [1:0]  state_r;
    logic [31:0] cnt_r;
    logic        sw_d_r;

    logic        rise_s;
    logic        fall_s;
    logic [1:0]  state_nxt_s;
    logic [31:0] cnt_nxt_s;
    logic        press_s;
    logic        release_s;
    logic        short_s;
    logic        long_s;
    logic        repeat_s;
    logic        held_s;

`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [31:0] REPEAT_M1 = REPEAT_CYCLES - 32'd1;
`else
    logic unused_repeat_cycles;
    assign unused_repeat_cycles = ^REPEAT_CYCLES;
`endif

    assign rise_s = sw_in & ~sw_d_r;
    assign fall_s = ~sw_in & sw_d_r;

    // Next-state, counter and pulse decode; a release always beats a coincident threshold.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        press_s     = 1'b0;
        release_s   = 1'b0;
        short_s     = 1'b0;
        long_s      = 1'b0;
        repeat_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt_s = PRESSED;
                    cnt_nxt_s   = 32'd0;
                    press_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESSED: begin
                if (fall_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 32'd0;
                    release_s   = 1'b1;
                    short_s     = 1'b1;
                end else if (sw_in) begin
                    if (cnt_r == LONG_M1) begin
                        state_nxt_s = LONG;
                        cnt_nxt_s   = 32'd0;
                        long_s      = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + 32'd1;
                    end
                end else begin
                    state_nxt_s = PRESSED;
                end
            end
            LONG: begin
                if (fall_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 32'd0;
                    release_s   = 1'b1;
                end else if (sw_in) begin
`ifdef KEY_EVENT_REPEAT_EN
                    if (cnt_r == REPEAT_M1) begin
                        cnt_nxt_s = 32'd0;
                        repeat_s  = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + 32'd1;
                    end
`else
                    cnt_nxt_s = cnt_r;
`endif
                end else begin
                    state_nxt_s = LONG;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 32'd0;
            end
        endcase
        held_s = (state_nxt_s != IDLE);
    end

    // State, counter, edge history and registered outputs; sw_d resets high so a key held through reset is ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            cnt_r         <= 32'd0;
            sw_d_r        <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            sw_d_r        <= sw_in;
            press_pulse   <= press_s;
            release_pulse <= release_s;
            short_press   <= short_s;
            long_press    <= long_s;
            repeat_pulse  <= repeat_s;
            held          <= held_s;
        end
    end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with LONG_CYCLES=10, REPEAT_CYCLES=4.
// Output vectors are {press, release, short, long, repeat, held}.
module tb_key_event;

    logic clk = 1'b0;
    logic rst;
    logic sw_in;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic repeat_pulse;
    logic held;

    int passes = 0;
    int total  = 0;
    int rep_seen;

`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    always #5 clk = ~clk;

    key_event #(
        .LONG_CYCLES  (32'd10),
        .REPEAT_CYCLES(32'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_in        (sw_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held};
        total = total + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    initial begin
        rst   = 1'b0;
        sw_in = 1'b0;
        step();
        step();
        chk("reset_idle", 6'b000000);
        rst = 1'b1;
        step();
        chk("idle_quiet", 6'b000000);

        // Short press: 5 high samples then release
        sw_in = 1'b1;
        step();
        chk("short_press_pulse", 6'b100001);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("short_hold", 6'b000001);
        end
        sw_in = 1'b0;
        step();
        chk("short_release", 6'b011000);
        step();
        chk("short_after", 6'b000000);

        // Long press, held long enough for five repeat thresholds
        sw_in = 1'b1;
        step();
        chk("long_press_pulse", 6'b100001);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("long_pre", 6'b000001);
        end
        step();
        chk("long_press", 6'b000101);
        rep_seen = 0;
        for (int k = 11; k <= 30; k++) begin
            logic rep_exp;
            step();
            rep_exp = REP && (((k - 10) % 4) == 0);
            if (repeat_pulse === 1'b1) rep_seen = rep_seen + 1;
            chk("long_hold", {4'b0000, rep_exp, 1'b1});
        end
        total = total + 1;
        assert (rep_seen === (REP ? 5 : 0)) passes = passes + 1;
        else $error("FAIL repeat_count observed=%0d expected=%0d", rep_seen, (REP ? 5 : 0));
        sw_in = 1'b0;
        step();
        chk("long_release", 6'b010000);
        step();
        chk("long_after", 6'b000000);

        // Release coincides with the long threshold: release wins
        sw_in = 1'b1;
        step();
        chk("bnd_press_pulse", 6'b100001);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("bnd_hold", 6'b000001);
        end
        sw_in = 1'b0;
        step();
        chk("bnd_release", 6'b011000);
        step();
        chk("bnd_after", 6'b000000);

        // Key held through reset must not produce a press
        sw_in = 1'b1;
        rst   = 1'b0;
        step();
        chk("rst_hold", 6'b000000);
        step();
        rst = 1'b1;
        step();
        chk("held_thru_rst", 6'b000000);
        step();
        chk("held_thru_rst2", 6'b000000);
        sw_in = 1'b0;
        step();
        chk("fall_in_idle", 6'b000000);
        sw_in = 1'b1;
        step();
        chk("repress", 6'b100001);
        sw_in = 1'b0;
        step();
        chk("repress_release", 6'b011000);
        step();

        // Reset while in LONG aborts silently
        sw_in = 1'b1;
        step();
        chk("rl_press_pulse", 6'b100001);
        for (int k = 1; k <= 9; k++) begin
            step();
        end
        step();
        chk("rl_long", 6'b000101);
        step();
        chk("rl_in_long", 6'b000001);
        rst = 1'b0;
        step();
        chk("rst_in_long", 6'b000000);
        rst   = 1'b1;
        sw_in = 1'b0;
        step();
        chk("no_release_after_rst", 6'b000000);
        step();
        chk("rl_after", 6'b000000);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 100000000, meaning held-cycles from press to long_press (legal range 2..2^32-1).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 20000000, meaning cycles between repeat_pulse outputs while long-held (legal range 2..2^32-1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sw_in  input  1  debounced key level from the debounce stage (1 = pressed).
REQ-006 SHALL have port press_pulse  output  1  one-cycle pulse on press.
REQ-007 SHALL have port release_pulse  output  1  one-cycle pulse on release.
REQ-008 SHALL have port short_press  output  1  one-cycle pulse on release before the long threshold.
REQ-009 SHALL have port long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
REQ-010 SHALL have port repeat_pulse  output  1  one-cycle auto-repeat pulse while long-held.
REQ-011 SHALL have port held  output  1  level, 1 while state is PRESSED or LONG.

Function
REQ-012 SHALL register sw_in into sw_d each cycle; rise = sw_in & ~sw_d, fall = ~sw_in & sw_d.
REQ-013 SHALL register all outputs; each pulse is high for exactly one cycle, in the cycle after the edge at which its condition is sampled.
REQ-014 SHALL implement states IDLE, PRESSED, LONG with a 32-bit hold counter cnt.
REQ-015 IDLE + rise: SHALL go to PRESSED, clear cnt to 0, assert press_pulse; IDLE + fall is ignored.
REQ-016 PRESSED + sw_in=1: SHALL increment cnt; at the edge where cnt == LONG_CYCLES-1, go to LONG, clear cnt, assert long_press.
REQ-017 PRESSED + fall: SHALL go to IDLE and assert release_pulse and short_press together.
REQ-018 LONG + sw_in=1: SHALL increment cnt; at cnt == REPEAT_CYCLES-1, assert repeat_pulse and clear cnt.
REQ-019 LONG + fall: SHALL go to IDLE and assert release_pulse only (no short_press, no repeat_pulse).
REQ-020 Simultaneous fall and threshold (cnt at LONG_CYCLES-1 or REPEAT_CYCLES-1): release SHALL win; the threshold pulse is suppressed.
REQ-021 cnt SHALL never wrap; it is cleared at every threshold and on entry to PRESSED.
REQ-022 long_press SHALL occur at most once per press; repeat_pulse SHALL never occur in PRESSED.
REQ-023 held SHALL rise with press_pulse and fall with release_pulse.

Reset
REQ-024 With rst=0 at a clock edge: state <= IDLE, cnt <= 0, all outputs <= 0, sw_d <= 1.
REQ-025 Because sw_d resets to 1, a key held through reset SHALL produce no press_pulse until released and pressed again.
REQ-026 Reset mid-press SHALL abort the press silently: no release_pulse, no short_press.

Configuration
REQ-027 Macro KEY_EVENT_REPEAT_EN defined: SHALL implement REQ-018 auto-repeat.
REQ-028 Macro KEY_EVENT_REPEAT_EN undefined: repeat_pulse SHALL be tied to 0, cnt SHALL hold in LONG, REPEAT_CYCLES is unused; all other behaviour is unchanged.

Verification (LONG_CYCLES=10, REPEAT_CYCLES=4)
REQ-029 Short press: sw_in high for 5 cycles, then low -> press_pulse once, then release_pulse and short_press in the same cycle; long_press stays 0.
REQ-030 Long press with repeat: sw_in high for 30 cycles -> long_press 10 cycles after press_pulse, then repeat_pulse every 4 cycles (5 pulses); release gives release_pulse only.
REQ-031 Same as REQ-030 without KEY_EVENT_REPEAT_EN -> long_press once, repeat_pulse never asserted.
REQ-032 Boundary: sw_in falls exactly at the edge where cnt=9 -> short_press and release_pulse asserted, long_press not asserted.
REQ-033 Reset with sw_in held high -> no press_pulse; after a release and a re-press, press_pulse appears 1 cycle after the rise.
REQ-034 rst pulsed low in LONG -> all outputs 0 the next cycle, no release_pulse, state IDLE.
